ll_multi_queue_engine: RTL and testbench
========================================

// Module: ll_multi_queue_engine
// PURPOSE
//  Parametrised multi-channel linked-list queue manager. Keeps NUM_Q independent FIFO queues of
//  KEY_WIDTH keys in one shared node pool of DEPTH entries. Owns its free-pointer FIFO and its
//  per-queue head/tail/count tables. Sits behind the hash-table command path as the next-generation
//  linked-list backend. One command in flight at a time; results return in command order.
// PARAMETERS
//  KEY_WIDTH  32  key/payload width stored per node
//  DEPTH      256 node pool size; power of two, >=4; A_W = $clog2(DEPTH)
//  NUM_Q      8   number of queues, >=1; Q_W = max(1,$clog2(NUM_Q)); C_W = A_W+1 (count width)
// PORTS
//  clk_i          in   1          clock
//  rst_i          in   1          reset, asynchronous, active-high
//  cmd_valid_i    in   1          command valid
//  cmd_ready_o    out  1          command accepted when valid&&ready
//  cmd_opcode_i   in   2          0=ENQ (append tail), 1=DEQ (pop head), 2=PEEK (read head), 3=NOP
//  cmd_qid_i      in   Q_W        target queue
//  cmd_key_i      in   KEY_WIDTH  key for ENQ, ignored otherwise
//  res_valid_o    out  1          result valid; held until res_ready_i
//  res_ready_i    in   1          result accepted when valid&&ready
//  res_opcode_o   out  2          echoed opcode
//  res_qid_o      out  Q_W        echoed qid
//  res_key_o      out  KEY_WIDTH  ENQ: echoed key; DEQ/PEEK OK: head key; else 0
//  res_rescode_o  out  2          0=OK, 1=EMPTY, 2=FULL, 3=BAD_QID
//  res_qlen_o     out  C_W        queue length after the operation (0 for BAD_QID)
//  init_done_o    out  1          free FIFO initialised
//  free_cnt_o     out  C_W        free nodes remaining
// BEHAVIOUR
//  Storage: key_ram[DEPTH] and next_ram[DEPTH], each with 1-cycle registered read; head/tail/cnt per
//   queue in flops. The free FIFO is DEPTH x A_W, circular rd/wr pointers.
//  Reset: all outputs 0, FSM=INIT, all cnt=0, free FIFO empty. Reset mid-operation aborts the command
//   and drops its result; the pool is re-initialised.
//  INIT: writes 0..DEPTH-1 into free FIFO, one per cycle (DEPTH cycles), then init_done_o=1, free_cnt_o=DEPTH.
//  IDLE: cmd_ready_o=1 only here and only when init_done_o=1. Accept edge = T.
//   BAD_QID (qid>=NUM_Q) or NOP -> RESP directly (NOP gives rescode OK, qlen = 0). No state changes.
//   ENQ, free_cnt=0 -> RESP with FULL. DEQ/PEEK, cnt[q]=0 -> RESP with EMPTY.
//  ENQ (1 cycle): n=free head; pop free; key_ram[n]=key; next_ram[n]=0; if cnt[q]!=0
//   next_ram[tail[q]]=n (same cycle, separate array) else head[q]=n; tail[q]=n; cnt[q]++ -> RESP.
//  DEQ_RD: read key_ram/next_ram[head[q]] -> DEQ_DATA: capture key; for DEQ: head[q]=next,
//   push old head to free FIFO, cnt[q]--; if cnt becomes 0 then head/tail are don't-care. PEEK: no change.
//  RESP: res_valid_o=1, fields stable until res_ready_i; on handshake -> IDLE. cmd_ready_o=0 in RESP,
//   so the next command is accepted at the earliest in the cycle after the result handshake.
//  Latency, acceptance to res_valid_o: ENQ 2 cycles, DEQ/PEEK 3 cycles, error/NOP 1 cycle.
//  Free FIFO push and pop never occur in the same cycle (single command in flight).
//  Counter wrap: impossible by construction. free_cnt + sum(cnt) == DEPTH is an invariant.
// CONFIGURATION
//  LLQ_WATERMARK_EN defined: adds ports hwm_o out NUM_Q*C_W (per-queue max cnt since reset/clear,
//   queue i at bits [i*C_W +: C_W]) and hwm_clr_i in 1. hwm_clr_i sets every hwm to the current cnt.
//   If hwm_clr_i and an ENQ update fall in the same cycle, the result is the post-ENQ cnt.
//   Reset value 0.
//  Undefined: these ports and registers are absent; all other behaviour is identical.
// TESTING
//  Post-reset: init_done_o rises exactly DEPTH cycles after deassert; free_cnt_o=DEPTH.
//  ENQ q0 keys 0xA,0xB,0xC; DEQ q0 x3 -> keys 0xA,0xB,0xC, qlen 2,1,0; 4th DEQ -> EMPTY.
//  Interleave ENQ q1 0x11, q2 0x22, q1 0x12; DEQ q1 -> 0x11; PEEK q2 -> 0x22 with qlen 1, queue unchanged.
//  Fill DEPTH nodes across queues; next ENQ -> FULL, free_cnt_o=0; one DEQ, then ENQ -> OK.
//  qid=NUM_Q -> BAD_QID, qlen 0; hold res_ready_i=0 for 5 cycles -> res fields stable, cmd_ready_o=0.
//  Assert rst_i in DEQ_DATA -> no result; after re-init all queues EMPTY; with LLQ_WATERMARK_EN hwm_o=0.

Source files
------------

// File: rtl/ll_multi_queue_engine_if.sv
// Command/result handshake bundle for the linked-list multi-queue engine.
// master = command issuer / result consumer, slave = engine.
interface ll_multi_queue_engine_if #(
    parameter int KEY_WIDTH = 32,
    parameter int DEPTH     = 256,
    parameter int NUM_Q     = 8
);
    localparam int Q_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int C_W = $clog2(DEPTH) + 1;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_opcode;
    logic [Q_W-1:0]       cmd_qid;
    logic [KEY_WIDTH-1:0] cmd_key;
    logic                 res_valid;
    logic                 res_ready;
    logic [1:0]           res_opcode;
    logic [Q_W-1:0]       res_qid;
    logic [KEY_WIDTH-1:0] res_key;
    logic [1:0]           res_rescode;
    logic [C_W-1:0]       res_qlen;

    modport master (
        output cmd_valid, cmd_opcode, cmd_qid, cmd_key, res_ready,
        input  cmd_ready, res_valid, res_opcode, res_qid, res_key, res_rescode, res_qlen
    );
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_qid, cmd_key, res_ready,
        output cmd_ready, res_valid, res_opcode, res_qid, res_key, res_rescode, res_qlen
    );
endinterface

// File: rtl/ll_multi_queue_engine.sv
// NUM_Q linked-list FIFOs sharing one DEPTH-node pool with an internal free-pointer FIFO.
// Optional per-queue high-watermark tracking when LLQ_WATERMARK_EN is defined.
module ll_multi_queue_engine #(
    parameter int KEY_WIDTH = 32,
    parameter int DEPTH     = 256,
    parameter int NUM_Q     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    ll_multi_queue_engine_if.slave    bus,
    output logic                      init_done_o,
    output logic [$clog2(DEPTH):0]    free_cnt_o
`ifdef LLQ_WATERMARK_EN
    ,
    output logic [NUM_Q*($clog2(DEPTH)+1)-1:0] hwm_o,
    input  logic                      hwm_clr_i
`endif
);
    localparam int A_W = $clog2(DEPTH);
    localparam int Q_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int C_W = A_W + 1;
    localparam logic [Q_W:0] NQ = (Q_W+1)'(NUM_Q);

    localparam logic [1:0] OP_ENQ = 2'd0, OP_DEQ = 2'd1, OP_PEEK = 2'd2;
    localparam logic [1:0] RC_OK = 2'd0, RC_EMPTY = 2'd1, RC_FULL = 2'd2, RC_BAD = 2'd3;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ENQ, S_DEQ_RD, S_DEQ_DATA, S_RESP} state_t;

    state_t               state;
    logic [KEY_WIDTH-1:0] key_ram  [DEPTH];
    logic [A_W-1:0]       next_ram [DEPTH];
    logic [A_W-1:0]       free_ram [DEPTH];
    logic [KEY_WIDTH-1:0] key_rd;
    logic [A_W-1:0]       next_rd;

    logic [A_W-1:0]       head    [NUM_Q];
    logic [A_W-1:0]       tail    [NUM_Q];
    logic [C_W-1:0]       cnt     [NUM_Q];
    logic [C_W-1:0]       cnt_nxt [NUM_Q];

    logic [A_W-1:0]       rd_ptr, wr_ptr, init_idx, free_head;
    logic [C_W-1:0]       free_cnt;
    logic                 init_done, cmd_ready;
    logic [1:0]           cur_op;
    logic [Q_W-1:0]       cur_qid;
    logic [KEY_WIDTH-1:0] cur_key;

    logic                 res_valid;
    logic [1:0]           res_opcode, res_rescode;
    logic [Q_W-1:0]       res_qid;
    logic [KEY_WIDTH-1:0] res_key;
    logic [C_W-1:0]       res_qlen;

    logic                 direct, deq_pop;
    logic [1:0]           d_rc;
    logic [KEY_WIDTH-1:0] d_key;
    logic [C_W-1:0]       d_qlen;

    assign free_head = free_ram[rd_ptr];
    assign deq_pop   = (state == S_DEQ_DATA) && (cur_op == OP_DEQ);

    // Decide in IDLE whether the command resolves without touching the pool.
    always_comb begin
        direct = 1'b1;
        d_rc   = RC_OK;
        d_key  = '0;
        d_qlen = '0;
        if ({1'b0, bus.cmd_qid} >= NQ) begin
            d_rc = RC_BAD;
        end else begin
            case (bus.cmd_opcode)
                OP_ENQ: begin
                    if (free_cnt == '0) begin
                        d_rc   = RC_FULL;
                        d_key  = bus.cmd_key;
                        d_qlen = cnt[bus.cmd_qid];
                    end else begin
                        direct = 1'b0;
                    end
                end
                OP_DEQ, OP_PEEK: begin
                    if (cnt[bus.cmd_qid] == '0) d_rc = RC_EMPTY;
                    else                        direct = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state == S_ENQ)  cnt_nxt[cur_qid] = cnt[cur_qid] + C_W'(1);
        else if (deq_pop)    cnt_nxt[cur_qid] = cnt[cur_qid] - C_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_INIT;
            init_done   <= 1'b0;
            cmd_ready   <= 1'b0;
            init_idx    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            free_cnt    <= '0;
            cur_op      <= '0;
            cur_qid     <= '0;
            cur_key     <= '0;
            res_valid   <= 1'b0;
            res_opcode  <= '0;
            res_qid     <= '0;
            res_key     <= '0;
            res_rescode <= '0;
            res_qlen    <= '0;
            for (int i = 0; i < NUM_Q; i++) begin
                head[i] <= '0;
                tail[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            case (state)
                S_INIT: begin
                    wr_ptr   <= wr_ptr + A_W'(1);
                    init_idx <= init_idx + A_W'(1);
                    free_cnt <= free_cnt + C_W'(1);
                    if (init_idx == A_W'(DEPTH-1)) begin
                        init_done <= 1'b1;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cur_op    <= bus.cmd_opcode;
                        cur_qid   <= bus.cmd_qid;
                        cur_key   <= bus.cmd_key;
                        if (direct) begin
                            res_valid   <= 1'b1;
                            res_opcode  <= bus.cmd_opcode;
                            res_qid     <= bus.cmd_qid;
                            res_key     <= d_key;
                            res_rescode <= d_rc;
                            res_qlen    <= d_qlen;
                            state       <= S_RESP;
                        end else if (bus.cmd_opcode == OP_ENQ) begin
                            state <= S_ENQ;
                        end else begin
                            state <= S_DEQ_RD;
                        end
                    end
                end
                S_ENQ: begin
                    rd_ptr   <= rd_ptr + A_W'(1);
                    free_cnt <= free_cnt - C_W'(1);
                    if (cnt[cur_qid] == '0) head[cur_qid] <= free_head;
                    tail[cur_qid] <= free_head;
                    res_valid   <= 1'b1;
                    res_opcode  <= cur_op;
                    res_qid     <= cur_qid;
                    res_key     <= cur_key;
                    res_rescode <= RC_OK;
                    res_qlen    <= cnt_nxt[cur_qid];
                    state       <= S_RESP;
                end
                S_DEQ_RD: state <= S_DEQ_DATA;
                S_DEQ_DATA: begin
                    if (deq_pop) begin
                        head[cur_qid] <= next_rd;
                        wr_ptr        <= wr_ptr + A_W'(1);
                        free_cnt      <= free_cnt + C_W'(1);
                    end
                    res_valid   <= 1'b1;
                    res_opcode  <= cur_op;
                    res_qid     <= cur_qid;
                    res_key     <= key_rd;
                    res_rescode <= RC_OK;
                    res_qlen    <= cnt_nxt[cur_qid];
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Pool storage: no reset, contents are rebuilt by INIT and ENQ.
    always_ff @(posedge clk_i) begin
        if (state == S_INIT) free_ram[wr_ptr] <= init_idx;
        if (deq_pop)         free_ram[wr_ptr] <= head[cur_qid];
        if (state == S_ENQ) begin
            key_ram[free_head]  <= cur_key;
            next_ram[free_head] <= '0;
            if (cnt[cur_qid] != '0) next_ram[tail[cur_qid]] <= free_head;
        end
        if (state == S_DEQ_RD) begin
            key_rd  <= key_ram[head[cur_qid]];
            next_rd <= next_ram[head[cur_qid]];
        end
    end

`ifdef LLQ_WATERMARK_EN
    logic [C_W-1:0] hwm [NUM_Q];

    // Follows cnt_nxt so a clear coinciding with an ENQ lands on the post-ENQ length.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_Q; i++) hwm[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_Q; i++)
                if (hwm_clr_i || cnt_nxt[i] > hwm[i]) hwm[i] <= cnt_nxt[i];
        end
    end

    for (genvar g = 0; g < NUM_Q; g++) begin : g_hwm
        assign hwm_o[g*C_W +: C_W] = hwm[g];
    end
`endif

    assign bus.cmd_ready   = cmd_ready;
    assign bus.res_valid   = res_valid;
    assign bus.res_opcode  = res_opcode;
    assign bus.res_qid     = res_qid;
    assign bus.res_key     = res_key;
    assign bus.res_rescode = res_rescode;
    assign bus.res_qlen    = res_qlen;
    assign init_done_o     = init_done;
    assign free_cnt_o      = free_cnt;
endmodule

// File: tb/tb_ll_multi_queue_engine.sv
// Directed bench for ll_multi_queue_engine: small pool, odd queue count so BAD_QID is reachable.
module tb_ll_multi_queue_engine;
    localparam int KW    = 16;
    localparam int DEPTH = 8;
    localparam int NUM_Q = 3;
    localparam int Q_W   = 2;
    localparam int C_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic init_done;
    logic [C_W-1:0] free_cnt;
    logic hwm_clr = 1'b0;
    logic [NUM_Q*C_W-1:0] hwm;

    int errors = 0;
    int checks = 0;

    logic [KW-1:0]  r_key;
    logic [1:0]     r_rc, r_op;
    logic [Q_W-1:0] r_qid;
    logic [C_W-1:0] r_ql;
    int             r_lat;

    always #5 clk = ~clk;

    ll_multi_queue_engine_if #(.KEY_WIDTH(KW), .DEPTH(DEPTH), .NUM_Q(NUM_Q)) bus ();

    ll_multi_queue_engine #(.KEY_WIDTH(KW), .DEPTH(DEPTH), .NUM_Q(NUM_Q)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .init_done_o (init_done),
        .free_cnt_o  (free_cnt)
`ifdef LLQ_WATERMARK_EN
        ,
        .hwm_o       (hwm),
        .hwm_clr_i   (hwm_clr)
`endif
    );

`ifndef LLQ_WATERMARK_EN
    assign hwm = '0;
`endif

    // Issue one command, wait for its result, capture fields, then complete the handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [Q_W-1:0] qid, input logic [KW-1:0] key);
        int n = 0;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_qid    = qid;
        bus.cmd_key    = key;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.cmd_ready) begin
            errors++; checks++;
            $display("FAIL cmd_accept: cmd_ready stayed %0b, required 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        r_lat = 1;
        while (!bus.res_valid && r_lat < 20) begin @(posedge clk); #1; r_lat++; end
        r_key = bus.res_key; r_rc = bus.res_rescode; r_ql = bus.res_qlen;
        r_op = bus.res_opcode; r_qid = bus.res_qid;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 4*DEPTH) begin @(posedge clk); #1; n++; end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_qid = '0; bus.cmd_key = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({init_done, free_cnt, bus.cmd_ready, bus.res_valid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: init=%0b free=%0d rdy=%0b rv=%0b, required all 0",
                     init_done, free_cnt, bus.cmd_ready, bus.res_valid);
        end
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (n !== DEPTH) begin errors++; $display("FAIL init_latency: got %0d cycles, required %0d", n, DEPTH); end
        checks++;
        if (free_cnt !== C_W'(DEPTH)) begin errors++; $display("FAIL init_free_cnt: got %0d, required %0d", free_cnt, DEPTH); end
        checks++;
        if (hwm !== '0) begin errors++; $display("FAIL reset_hwm: got %0h, required 0", hwm); end
    endtask

    task automatic test_fifo_order;
        logic [KW-1:0] k [3] = '{16'h000A, 16'h000B, 16'h000C};
        for (int i = 0; i < 3; i++) begin
            do_cmd(2'd0, 2'd0, k[i]);
            checks++;
            if (r_rc !== 2'd0 || r_ql !== C_W'(i+1) || r_key !== k[i] || r_op !== 2'd0) begin
                errors++;
                $display("FAIL enq_q0_%0d: rc=%0d qlen=%0d key=%h, required rc=0 qlen=%0d key=%h", i, r_rc, r_ql, r_key, i+1, k[i]);
            end
            if (i == 0) begin
                checks++;
                if (r_lat !== 2) begin errors++; $display("FAIL enq_latency: got %0d, required 2", r_lat); end
            end
        end
`ifdef LLQ_WATERMARK_EN
        checks++;
        if (hwm[0 +: C_W] !== C_W'(3)) begin errors++; $display("FAIL hwm_q0: got %0d, required 3", hwm[0 +: C_W]); end
`endif
        for (int i = 0; i < 3; i++) begin
            do_cmd(2'd1, 2'd0, '0);
            checks++;
            if (r_rc !== 2'd0 || r_key !== k[i] || r_ql !== C_W'(2-i)) begin
                errors++;
                $display("FAIL deq_q0_%0d: rc=%0d key=%h qlen=%0d, required rc=0 key=%h qlen=%0d", i, r_rc, r_key, r_ql, k[i], 2-i);
            end
            if (i == 0) begin
                checks++;
                if (r_lat !== 3) begin errors++; $display("FAIL deq_latency: got %0d, required 3", r_lat); end
            end
        end
        do_cmd(2'd1, 2'd0, '0);
        checks++;
        if (r_rc !== 2'd1 || r_ql !== '0 || r_key !== '0 || r_lat !== 1) begin
            errors++;
            $display("FAIL deq_empty: rc=%0d qlen=%0d key=%h lat=%0d, required rc=1 qlen=0 key=0 lat=1", r_rc, r_ql, r_key, r_lat);
        end
        checks++;
        if (free_cnt !== C_W'(DEPTH)) begin errors++; $display("FAIL free_after_drain: got %0d, required %0d", free_cnt, DEPTH); end
`ifdef LLQ_WATERMARK_EN
        hwm_clr = 1'b1; @(posedge clk); #1; hwm_clr = 1'b0;
        checks++;
        if (hwm[0 +: C_W] !== '0) begin errors++; $display("FAIL hwm_clear: got %0d, required 0", hwm[0 +: C_W]); end
`endif
    endtask

    task automatic test_interleave;
        do_cmd(2'd0, 2'd1, 16'h0011);
        do_cmd(2'd0, 2'd2, 16'h0022);
        do_cmd(2'd0, 2'd1, 16'h0012);
        checks++;
        if (r_ql !== C_W'(2)) begin errors++; $display("FAIL enq_q1_len: got %0d, required 2", r_ql); end
        do_cmd(2'd1, 2'd1, '0);
        checks++;
        if (r_key !== 16'h0011 || r_ql !== C_W'(1) || r_qid !== 2'd1) begin
            errors++; $display("FAIL deq_q1: key=%h qlen=%0d qid=%0d, required key=0011 qlen=1 qid=1", r_key, r_ql, r_qid);
        end
        for (int i = 0; i < 2; i++) begin
            do_cmd(2'd2, 2'd2, '0);
            checks++;
            if (r_rc !== 2'd0 || r_key !== 16'h0022 || r_ql !== C_W'(1) || r_op !== 2'd2) begin
                errors++; $display("FAIL peek_q2_%0d: rc=%0d key=%h qlen=%0d op=%0d, required rc=0 key=0022 qlen=1 op=2", i, r_rc, r_key, r_ql, r_op);
            end
        end
        checks++;
        if (free_cnt !== C_W'(DEPTH-2)) begin errors++; $display("FAIL free_interleave: got %0d, required %0d", free_cnt, DEPTH-2); end
        do_cmd(2'd1, 2'd1, '0);
        checks++;
        if (r_key !== 16'h0012 || r_ql !== '0) begin errors++; $display("FAIL deq_q1_second: key=%h qlen=%0d, required 0012 and 0", r_key, r_ql); end
        do_cmd(2'd1, 2'd2, '0);
        checks++;
        if (r_key !== 16'h0022 || free_cnt !== C_W'(DEPTH)) begin
            errors++; $display("FAIL deq_q2: key=%h free=%0d, required 0022 and %0d", r_key, free_cnt, DEPTH);
        end
    endtask

    task automatic test_full;
        logic [KW-1:0] exp_q [NUM_Q][3] = '{'{16'h0103, 16'h0106, 16'h0200},
                                            '{16'h0101, 16'h0104, 16'h0107},
                                            '{16'h0102, 16'h0105, 16'h0000}};
        int len [NUM_Q] = '{3, 3, 2};
        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(2'd0, Q_W'(i % NUM_Q), KW'(16'h0100 + i));
            checks++;
            if (r_rc !== 2'd0 || r_ql !== C_W'(i/NUM_Q + 1)) begin
                errors++; $display("FAIL fill_%0d: rc=%0d qlen=%0d, required rc=0 qlen=%0d", i, r_rc, r_ql, i/NUM_Q + 1);
            end
        end
        checks++;
        if (free_cnt !== '0) begin errors++; $display("FAIL free_full: got %0d, required 0", free_cnt); end
        do_cmd(2'd0, 2'd0, 16'h0999);
        checks++;
        if (r_rc !== 2'd2 || r_ql !== C_W'(3) || r_lat !== 1) begin
            errors++; $display("FAIL enq_full: rc=%0d qlen=%0d lat=%0d, required rc=2 qlen=3 lat=1", r_rc, r_ql, r_lat);
        end
        do_cmd(2'd1, 2'd0, '0);
        checks++;
        if (r_key !== 16'h0100 || r_ql !== C_W'(2)) begin errors++; $display("FAIL deq_when_full: key=%h qlen=%0d, required 0100 and 2", r_key, r_ql); end
        do_cmd(2'd0, 2'd0, 16'h0200);
        checks++;
        if (r_rc !== 2'd0 || r_ql !== C_W'(3) || free_cnt !== '0) begin
            errors++; $display("FAIL enq_reuse: rc=%0d qlen=%0d free=%0d, required 0, 3, 0", r_rc, r_ql, free_cnt);
        end
        for (int q = 0; q < NUM_Q; q++)
            for (int j = 0; j < len[q]; j++) begin
                do_cmd(2'd1, Q_W'(q), '0);
                checks++;
                if (r_rc !== 2'd0 || r_key !== exp_q[q][j]) begin
                    errors++; $display("FAIL drain_q%0d_%0d: rc=%0d key=%h, required rc=0 key=%h", q, j, r_rc, r_key, exp_q[q][j]);
                end
            end
        checks++;
        if (free_cnt !== C_W'(DEPTH)) begin errors++; $display("FAIL free_after_full_drain: got %0d, required %0d", free_cnt, DEPTH); end
    endtask

    task automatic test_bad_qid;
        int n = 0;
        do_cmd(2'd3, 2'd0, 16'h1234);
        checks++;
        if (r_rc !== 2'd0 || r_ql !== '0 || r_key !== '0 || r_op !== 2'd3 || r_lat !== 1) begin
            errors++; $display("FAIL nop: rc=%0d qlen=%0d key=%h op=%0d lat=%0d, required 0,0,0,3,1", r_rc, r_ql, r_key, r_op, r_lat);
        end
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 2'd1; bus.cmd_qid = 2'(NUM_Q); bus.cmd_key = 16'hBEEF;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_rescode !== 2'd3 || bus.res_qlen !== '0 ||
                bus.res_qid !== 2'(NUM_Q) || bus.res_key !== '0 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_qid_hold_%0d: rv=%0b rc=%0d qlen=%0d qid=%0d key=%h rdy=%0b, required 1,3,0,%0d,0,0",
                         c, bus.res_valid, bus.res_rescode, bus.res_qlen, bus.res_qid, bus.res_key, bus.cmd_ready, NUM_Q);
            end
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1; @(posedge clk); #1; bus.res_ready = 1'b0;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bad_qid_release: rv=%0b rdy=%0b, required 0 and 1", bus.res_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do_cmd(2'd0, 2'd2, 16'h0055);
        do_cmd(2'd0, 2'd1, 16'h0066);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 2'd1; bus.cmd_qid = 2'd2; bus.cmd_key = '0;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;          // accepted, now DEQ_RD
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;          // now DEQ_DATA
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_res_%0d: rv=%0b, required 0", c, bus.res_valid); end
        end
        rst = 1'b0;
        wait_init(n);
        checks++;
        if (init_done !== 1'b1 || free_cnt !== C_W'(DEPTH) || hwm !== '0) begin
            errors++; $display("FAIL reinit: done=%0b free=%0d hwm=%0h, required 1, %0d, 0", init_done, free_cnt, hwm, DEPTH);
        end
        for (int q = 0; q < NUM_Q; q++) begin
            do_cmd(2'd2, Q_W'(q), '0);
            checks++;
            if (r_rc !== 2'd1 || r_ql !== '0) begin errors++; $display("FAIL reinit_empty_q%0d: rc=%0d qlen=%0d, required 1 and 0", q, r_rc, r_ql); end
        end
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_interleave();
        test_full();
        test_bad_qid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
